// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller slice.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FAULT = 2'd2
    } hazState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // Register zero is hardwired, so it never creates a dependency.
    function automatic logic loadUse(input logic [4:0] exRd, input logic exMemRead,
                                     input logic [4:0] idRs, input logic [4:0] idRt,
                                     input logic idUsesRt);
        return exMemRead && (exRd != REG_ZERO) &&
               ((exRd == idRs) || (idUsesRt && (exRd == idRt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count enabled events, stick at the maximum instead of wrapping.
    always_ff @(posedge clock) begin
        if (clear)
            q <= '0;
        else if (en && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stage enable/flush sequencing for the 5-stage pipeline: load-use bubbles,
// MEM redirects, multi-cycle data-memory waits with timeout supervision.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_redirect,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] wait_cnt_tot
);

    hazState_t        stateQ;
    logic [CNT_W-1:0] waitCnt;
    logic             lu, mw, frozen, active;
    logic             luEv, redirEv, waitEv;

    assign lu     = loadUse(ex_rd, ex_memread, id_rs, id_rt, id_uses_rt);
    assign mw     = mem_access && !mem_ready;
    // Once waiting, only mem_ready releases the freeze.
    assign frozen = (stateQ == ST_MWAIT) ? !mem_ready : mw;
    assign active = !reset && (stateQ != ST_FAULT);

    assign waitEv  = active && frozen;
    assign redirEv = active && !frozen && mem_redirect;
    // A redirect squashes the EX load, so its bubble is not needed.
    assign luEv    = active && !frozen && !mem_redirect && lu;

    assign fault = !reset && (stateQ == ST_FAULT);
    assign state = stateQ;

    // Stage enables/flushes by priority: reset, fault, freeze, redirect, load-use.
    always_comb begin
        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
        {ifid_flush, idex_flush, exmem_flush}         = 3'b000;
        if (reset) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (stateQ == ST_FAULT || frozen) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
        end else if (mem_redirect) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        end else if (lu) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // FSM plus consecutive-wait counter; FAULT is left only through reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ  <= ST_RUN;
            waitCnt <= '0;
        end else begin
            case (stateQ)
                ST_RUN: begin
                    if (mw) begin
                        stateQ  <= ST_MWAIT;
                        waitCnt <= CNT_W'(1);
                    end
                end
                ST_MWAIT: begin
                    if (mem_ready) begin
                        stateQ  <= ST_RUN;
                        waitCnt <= '0;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        stateQ <= ST_FAULT;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: stateQ <= ST_FAULT;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) uLuCnt (
        .clock(clock), .clear(reset), .en(luEv), .q(lu_cnt)
    );

    sat_counter #(.W(CNT_W)) uRedirCnt (
        .clock(clock), .clear(reset), .en(redirEv), .q(redir_cnt)
    );

    sat_counter #(.W(CNT_W)) uWaitCnt (
        .clock(clock), .clear(reset), .en(waitEv), .q(wait_cnt_tot)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a
// cycle-level reference model (mode, consecutive frozen cycles, event counts).
module tb_pipeline_hazard_controller;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rt, ex_memread, mem_redirect, mem_access, mem_ready;
    logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic          ifid_flush, idex_flush, exmem_flush, fault;
    logic [1:0]    state;
    logic [CW-1:0] lu_cnt, redir_cnt, wait_cnt_tot;

    pipeline_hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_redirect(mem_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fault(fault), .state(state),
        .lu_cnt(lu_cnt), .redir_cnt(redir_cnt), .wait_cnt_tot(wait_cnt_tot)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 run / 1 waiting / 2 fault.
    int mode = 0, waitRun = 0, mLu = 0, mRedir = 0, mWait = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registers.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic usesRt, input logic [4:0] rd, input logic memRd,
                        input logic redir, input logic acc, input logic rdy);
        logic [4:0] eWe;
        logic [2:0] eFl;
        logic       eFault, isLu, frz;
        @(negedge clock);
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = usesRt; ex_rd = rd;
        ex_memread = memRd; mem_redirect = redir; mem_access = acc; mem_ready = rdy;
        #1;
        isLu = memRd && (rd != 0) && (rd == rs || (usesRt && rd == rt));
        frz  = (mode == 1) ? !rdy : (mode == 0 && acc && !rdy);
        eFault = 1'b0;
        eWe = 5'b11111; eFl = 3'b000;
        if (rst) begin
            eWe = 5'b00000; eFl = 3'b111;
        end else if (mode == 2) begin
            eWe = 5'b00000; eFault = 1'b1;
        end else if (frz) begin
            eWe = 5'b00000;
        end else if (redir) begin
            eFl = 3'b111;
        end else if (isLu) begin
            eWe = 5'b00111; eFl = 3'b010;
        end
        chk("we",    {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, eWe);
        chk("flush", {ifid_flush, idex_flush, exmem_flush}, eFl);
        chk("fault", fault, eFault);
        chk("state", state, mode);
        if (rst) begin
            mode = 0; waitRun = 0; mLu = 0; mRedir = 0; mWait = 0;
        end else if (mode != 2) begin
            if (frz) begin
                waitRun++;
                mWait = sat(mWait);
                mode = (waitRun >= TO) ? 2 : 1;
            end else begin
                mode = 0; waitRun = 0;
                if (redir)     mRedir = sat(mRedir);
                else if (isLu) mLu = sat(mLu);
            end
        end
        @(posedge clock);
        #1;
        chk("state_q",   state, mode);
        chk("lu_cnt",    lu_cnt, mLu);
        chk("redir_cnt", redir_cnt, mRedir);
        chk("wait_tot",  wait_cnt_tot, mWait);
    endtask

    task automatic idle();
        step(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rd = 0;
        ex_memread = 0; mem_redirect = 0; mem_access = 0; mem_ready = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // load-use on rs: single bubble
        step(0, 5'd8, 5'd3, 0, 5'd8, 1, 0, 0, 1);
        chk("t1_lu_cnt", lu_cnt, 1);
        // destination r0 never stalls
        step(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 1);
        chk("t2_lu_cnt", lu_cnt, 1);
        // rt dependency only counts when rt is read
        step(0, 5'd4, 5'd9, 0, 5'd9, 1, 0, 0, 1);
        step(0, 5'd4, 5'd9, 1, 5'd9, 1, 0, 0, 1);
        chk("rt_lu_cnt", lu_cnt, 2);

        // three frozen cycles then release
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("t3_wait_tot", wait_cnt_tot, 3);
        chk("t3_state", state, 0);

        // redirect wins over load-use
        step(0, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0, 1);
        chk("t4_redir", redir_cnt, 1);
        chk("t4_lu", lu_cnt, 2);

        // timeout into fault, then reset recovers
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t5_state", state, 2);
        step(0, 5'd7, 5'd0, 0, 5'd7, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_rst_state", state, 0);

        // saturation of lu_cnt
        repeat (20) step(0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 1);
        chk("t6_sat", lu_cnt, 15);
        // reset mid-wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t6_rst_state", state, 0);
        chk("t6_rst_lu", lu_cnt, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 3),
                 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                 5'($urandom_range(3)), ($urandom_range(99) < 50),
                 ($urandom_range(99) < 20), ($urandom_range(99) < 30),
                 ($urandom_range(99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
